// File: rtl/counter_run_arbiter.sv
// counter_run_arbiter: round-robin sequencer sharing one WIDTH-bit run counter
// between two requesters. A granted requester gets a count from 0 up to its
// sampled length, followed by a one-cycle done pulse.
// Optional feature macro: COUNTER_RUN_ARBITER_PRESCALE_EN (count advances once
// every PRESCALE cycles instead of every cycle).
module counter_run_arbiter #(
  parameter int WIDTH    = 8,
  parameter int PRESCALE = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req0,
  input  logic [WIDTH-1:0] len0,
  input  logic             req1,
  input  logic [WIDTH-1:0] len1,
  output logic             gnt0,
  output logic             gnt1,
  output logic             busy,
  output logic [WIDTH-1:0] q,
  output logic             done0,
  output logic             done1
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // A prescale ratio below 2 would make the divided tick meaningless.
  if (PRESCALE < 2) begin : g_prescale_check
    $error("counter_run_arbiter: PRESCALE must be >= 2");
  end

  state_t           state_q, state_d;
  logic             gnt0_q, gnt0_d;
  logic             gnt1_q, gnt1_d;
  logic             done0_q, done0_d;
  logic             done1_q, done1_d;
  logic             busy_q, busy_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] target_q, target_d;
  // last_q: 1 means requester 1 was served last, so requester 0 wins a tie.
  logic             last_q, last_d;

  logic             pick1;
  logic [WIDTH-1:0] len_w;
  logic [WIDTH-1:0] q_inc;
  logic             granted_req;
  logic             tick;

`ifdef COUNTER_RUN_ARBITER_PRESCALE_EN
  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(PRESCALE - 1);
  logic [PW-1:0] pre_q, pre_d;

  // Tick fires on the last cycle of each prescale period.
  always_comb begin
    tick = (pre_q == PRE_MAX);
  end
`else
  // Without prescaling the counter advances on every edge while running.
  always_comb begin
    tick = 1'b1;
  end
`endif

  // Arbitration and counter next-state; every output is computed here and
  // registered below so nothing combinational reaches the ports.
  always_comb begin
    state_d  = state_q;
    gnt0_d   = gnt0_q;
    gnt1_d   = gnt1_q;
    done0_d  = 1'b0;
    done1_d  = 1'b0;
    q_d      = q_q;
    target_d = target_q;
    last_d   = last_q;
    pick1       = req1 && (!req0 || !last_q);
    len_w       = pick1 ? len1 : len0;
    q_inc       = q_q + {{(WIDTH-1){1'b0}}, 1'b1};
    granted_req = gnt1_q ? req1 : req0;
`ifdef COUNTER_RUN_ARBITER_PRESCALE_EN
    pre_d = pre_q;
`endif
    unique case (state_q)
      IDLE: begin
        if (req0 || req1) begin
          gnt0_d   = !pick1;
          gnt1_d   = pick1;
          q_d      = '0;
          target_d = len_w;
`ifdef COUNTER_RUN_ARBITER_PRESCALE_EN
          pre_d = '0;
`endif
          if (len_w == '0) begin
            state_d = DONE;
            done0_d = !pick1;
            done1_d = pick1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        if (!granted_req) begin
          state_d = IDLE;
          gnt0_d  = 1'b0;
          gnt1_d  = 1'b0;
          last_d  = gnt1_q;
        end else begin
`ifdef COUNTER_RUN_ARBITER_PRESCALE_EN
          pre_d = tick ? '0 : pre_q + {{(PW-1){1'b0}}, 1'b1};
`endif
          if (tick) begin
            q_d = q_inc;
            if (q_inc == target_q) begin
              state_d = DONE;
              done0_d = gnt0_q;
              done1_d = gnt1_q;
            end
          end
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
        last_d  = gnt1_q;
      end
      default: begin
        state_d = IDLE;
        gnt0_d  = 1'b0;
        gnt1_d  = 1'b0;
      end
    endcase
    busy_d = (state_d != IDLE);
  end

  // State register with synchronous active-low reset that favours requester 0.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= IDLE;
      gnt0_q   <= 1'b0;
      gnt1_q   <= 1'b0;
      done0_q  <= 1'b0;
      done1_q  <= 1'b0;
      busy_q   <= 1'b0;
      q_q      <= '0;
      target_q <= '0;
      last_q   <= 1'b1;
`ifdef COUNTER_RUN_ARBITER_PRESCALE_EN
      pre_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      gnt0_q   <= gnt0_d;
      gnt1_q   <= gnt1_d;
      done0_q  <= done0_d;
      done1_q  <= done1_d;
      busy_q   <= busy_d;
      q_q      <= q_d;
      target_q <= target_d;
      last_q   <= last_d;
`ifdef COUNTER_RUN_ARBITER_PRESCALE_EN
      pre_q    <= pre_d;
`endif
    end
  end

  assign gnt0  = gnt0_q;
  assign gnt1  = gnt1_q;
  assign done0 = done0_q;
  assign done1 = done1_q;
  assign busy  = busy_q;
  assign q     = q_q;

endmodule

// File: tb/tb_counter_run_arbiter.sv
// Directed self-checking bench for counter_run_arbiter.
// Inputs change and outputs are sampled 1 time unit after each rising edge.
module tb_counter_run_arbiter;
  localparam int WIDTH    = 8;
  localparam int PRESCALE = 4;

  logic             clk = 1'b0;
  logic             rst;
  logic             req0, req1;
  logic [WIDTH-1:0] len0, len1;
  logic             gnt0, gnt1, busy, done0, done1;
  logic [WIDTH-1:0] q;

  int checks = 0;
  int errors = 0;

  counter_run_arbiter #(.WIDTH(WIDTH), .PRESCALE(PRESCALE)) dut (
    .clk(clk), .rst(rst),
    .req0(req0), .len0(len0), .req1(req1), .len1(len1),
    .gnt0(gnt0), .gnt1(gnt1), .busy(busy), .q(q),
    .done0(done0), .done1(done1)
  );

  always #5 clk = ~clk;

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b0; len0 = 8'd5; len1 = 8'd0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({gnt0, gnt1, busy, done0, done1} !== 5'b00000) begin
        errors++;
        $display("[TB] FAIL reset_ctrl cyc%0d: got gnt0,gnt1,busy,done0,done1=%b exp 00000", i, {gnt0, gnt1, busy, done0, done1});
      end
      checks++;
      if (q !== 8'd0) begin
        errors++;
        $display("[TB] FAIL reset_q cyc%0d: got %0d exp 0", i, q);
      end
    end
    req0 = 1'b0;
    rst  = 1'b1;
    step();
  endtask

  task automatic test_single_run();
    req0 = 1'b1; len0 = 8'd5;
    step();
    checks++;
    if ({gnt0, gnt1, busy, done0, q} !== {4'b1010, 8'd0}) begin
      errors++;
      $display("[TB] FAIL single_grant: got gnt0,gnt1,busy,done0=%b q=%0d exp 1010 q=0", {gnt0, gnt1, busy, done0}, q);
    end
    len0 = 8'd2;
    for (int k = 1; k <= 5; k++) begin
      step();
      checks++;
      if (q !== k[WIDTH-1:0] || gnt0 !== 1'b1 || done0 !== (k == 5)) begin
        errors++;
        $display("[TB] FAIL single_count k=%0d: got q=%0d gnt0=%b done0=%b exp q=%0d gnt0=1 done0=%b", k, q, gnt0, done0, k, (k == 5));
      end
    end
    req0 = 1'b0;
    step();
    checks++;
    if ({gnt0, busy, done0} !== 3'b000 || q !== 8'd5) begin
      errors++;
      $display("[TB] FAIL single_end: got gnt0,busy,done0=%b q=%0d exp 000 q=5", {gnt0, busy, done0}, q);
    end
  endtask

  task automatic test_contention();
    rst = 1'b0; req0 = 1'b1; req1 = 1'b1; len0 = 8'd3; len1 = 8'd3;
    step();
    rst = 1'b1;
    step();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL contend_first: got gnt0,gnt1=%b exp 10", {gnt0, gnt1});
    end
    step(); step(); step();
    checks++;
    if ({done0, done1, q} !== {2'b10, 8'd3}) begin
      errors++;
      $display("[TB] FAIL contend_done0: got done0,done1=%b q=%0d exp 10 q=3", {done0, done1}, q);
    end
    req0 = 1'b0;
    step();
    checks++;
    if ({gnt0, gnt1, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL contend_idle: got gnt0,gnt1,busy=%b exp 000", {gnt0, gnt1, busy});
    end
    step();
    checks++;
    if ({gnt0, gnt1, q} !== {2'b01, 8'd0}) begin
      errors++;
      $display("[TB] FAIL contend_second: got gnt0,gnt1=%b q=%0d exp 01 q=0", {gnt0, gnt1}, q);
    end
    req0 = 1'b1;
    step(); step(); step();
    checks++;
    if ({done0, done1, gnt1} !== 3'b011) begin
      errors++;
      $display("[TB] FAIL contend_done1: got done0,done1,gnt1=%b exp 011", {done0, done1, gnt1});
    end
    step();
    step();
    checks++;
    if ({gnt0, gnt1} !== 2'b10) begin
      errors++;
      $display("[TB] FAIL contend_third: got gnt0,gnt1=%b exp 10", {gnt0, gnt1});
    end
    req0 = 1'b0; req1 = 1'b0;
    step();
    step();
  endtask

  task automatic test_zero_length();
    req1 = 1'b1; len1 = 8'd0;
    step();
    checks++;
    if ({gnt0, gnt1, done0, done1, busy} !== 5'b01011 || q !== 8'd0) begin
      errors++;
      $display("[TB] FAIL zero_grant: got gnt0,gnt1,done0,done1,busy=%b q=%0d exp 01011 q=0", {gnt0, gnt1, done0, done1, busy}, q);
    end
    req1 = 1'b0;
    step();
    checks++;
    if ({gnt1, done1, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL zero_idle: got gnt1,done1,busy=%b exp 000", {gnt1, done1, busy});
    end
  endtask

  task automatic test_abort_and_reset();
    req0 = 1'b1; len0 = 8'd9; len1 = 8'd9;
    step();
    req1 = 1'b1;
    step(); step();
    checks++;
    if (q !== 8'd2 || gnt0 !== 1'b1) begin
      errors++;
      $display("[TB] FAIL abort_pre: got q=%0d gnt0=%b exp q=2 gnt0=1", q, gnt0);
    end
    req0 = 1'b0;
    step();
    checks++;
    if ({gnt0, gnt1, busy, done0, done1} !== 5'b00000 || q !== 8'd2) begin
      errors++;
      $display("[TB] FAIL abort_idle: got gnt0,gnt1,busy,done0,done1=%b q=%0d exp 00000 q=2", {gnt0, gnt1, busy, done0, done1}, q);
    end
    step();
    checks++;
    if ({gnt0, gnt1} !== 2'b01 || q !== 8'd0) begin
      errors++;
      $display("[TB] FAIL abort_next: got gnt0,gnt1=%b q=%0d exp 01 q=0", {gnt0, gnt1}, q);
    end
    step(); step(); step(); step();
    checks++;
    if (q !== 8'd4) begin
      errors++;
      $display("[TB] FAIL midreset_pre: got q=%0d exp 4", q);
    end
    rst = 1'b0;
    step();
    checks++;
    if ({gnt0, gnt1, busy, done0, done1} !== 5'b00000 || q !== 8'd0) begin
      errors++;
      $display("[TB] FAIL midreset: got gnt0,gnt1,busy,done0,done1=%b q=%0d exp 00000 q=0", {gnt0, gnt1, busy, done0, done1}, q);
    end
    rst = 1'b1; req1 = 1'b0;
    step();
  endtask

  task automatic test_prescale();
    int n;
    logic [WIDTH-1:0] exp_q;
`ifdef COUNTER_RUN_ARBITER_PRESCALE_EN
    n = 2 * PRESCALE;
`else
    n = 2;
`endif
    req0 = 1'b1; len0 = 8'd2;
    step();
    for (int k = 1; k <= n; k++) begin
      step();
`ifdef COUNTER_RUN_ARBITER_PRESCALE_EN
      exp_q = WIDTH'(k / PRESCALE);
`else
      exp_q = WIDTH'(k);
`endif
      checks++;
      if (q !== exp_q || done0 !== (k == n) || gnt0 !== 1'b1) begin
        errors++;
        $display("[TB] FAIL prescale k=%0d: got q=%0d done0=%b gnt0=%b exp q=%0d done0=%b gnt0=1", k, q, done0, gnt0, exp_q, (k == n));
      end
    end
    req0 = 1'b0;
    step();
    checks++;
    if ({gnt0, done0, busy} !== 3'b000) begin
      errors++;
      $display("[TB] FAIL prescale_end: got gnt0,done0,busy=%b exp 000", {gnt0, done0, busy});
    end
  endtask

  // Guard: the two grants must never be high together.
  always @(negedge clk) begin
    if (gnt0 === 1'b1 && gnt1 === 1'b1) begin
      errors++;
      $display("[TB] FAIL gnt_exclusive: got gnt0=1 gnt1=1 exp at most one");
    end
  end

  initial begin
    rst = 1'b0; req0 = 1'b0; req1 = 1'b0; len0 = '0; len1 = '0;
    #1;
    test_reset();
    test_single_run();
    test_contention();
    test_zero_length();
    test_abort_and_reset();
    test_prescale();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
